// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per clock with first/last bit framing strobes.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             last_bit
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             accept;

  // Ready also on the final bit so a waiting word follows with no idle gap.
  assign at_last    = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || at_last;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= data_in;
      cnt   <= '0;
    end else if (at_last) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
    end
  end

  // The shift register is zero whenever idle, so ser_out needs no state gating.
  assign ser_out     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign ser_valid   = (state == SHIFT);
  assign frame_start = (state == SHIFT) && (cnt == '0);
  assign last_bit    = at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance, each checked
// against a queue of expected serial bits built from the accepted words.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic         lv_m, lv_l;
  logic [W-1:0] d_m, d_l;
  logic         rdy_m, so_m, sv_m, fs_m, lb_m;
  logic         rdy_l, so_l, sv_l, fs_l, lb_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Bits still to appear on each instance's ser_out, front = current bit.
  bit mq[$];
  bit lq[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clear(clear), .load_valid(lv_m), .data_in(d_m),
    .load_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m),
    .frame_start(fs_m), .last_bit(lb_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clear(clear), .load_valid(lv_l), .data_in(d_l),
    .load_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l),
    .frame_start(fs_l), .last_bit(lb_l)
  );

  // Expected {load_ready, ser_valid, ser_out, frame_start, last_bit}.
  function automatic logic [4:0] exp_vec(input bit is_msb);
    int n;
    bit b;
    n = is_msb ? mq.size() : lq.size();
    b = 1'b0;
    if (n > 0) b = is_msb ? mq[0] : lq[0];
    return {n <= 1, n > 0, b, n == W, n == 1};
  endfunction

  function automatic void model_edge(input bit is_msb, input logic lv, input logic [W-1:0] d);
    bit acc;
    if (is_msb) begin
      acc = lv && (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) for (int i = 0; i < W; i++) mq.push_back(d[W-1-i]);
    end else begin
      acc = lv && (lq.size() <= 1);
      if (lq.size() > 0) void'(lq.pop_front());
      if (acc) for (int i = 0; i < W; i++) lq.push_back(d[i]);
    end
  endfunction

  // Drive inputs for the coming rising edge and advance the model to match.
  task automatic drive(input logic lvm, input logic [W-1:0] dm,
                       input logic lvl, input logic [W-1:0] dl);
    lv_m = lvm; d_m = dm; lv_l = lvl; d_l = dl;
    model_edge(1'b1, lvm, dm);
    model_edge(1'b0, lvl, dl);
  endtask

  task automatic test_reset();
    logic [4:0] got;
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {rdy_m, sv_m, so_m, fs_m, lb_m};
      n_cmp++;
      if (got !== 5'b10000) begin
        n_bad++;
        $display("[TB] FAIL reset_msb cyc%0d rdy/sv/so/fs/lb got=%b exp=10000", i, got);
      end
      got = {rdy_l, sv_l, so_l, fs_l, lb_l};
      n_cmp++;
      if (got !== 5'b10000) begin
        n_bad++;
        $display("[TB] FAIL reset_lsb cyc%0d rdy/sv/so/fs/lb got=%b exp=10000", i, got);
      end
      lv_m = 1'b1; d_m = W'($urandom); lv_l = 1'b1; d_l = W'($urandom);
    end
    lv_m = 1'b0; lv_l = 1'b0;
    clear = 1'b1;
  endtask

  task automatic test_single();
    logic [4:0] got, exp;
    logic [3:0] s = '0;
    int nv = 0;
    bit pend = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      got = {rdy_m, sv_m, so_m, fs_m, lb_m}; exp = exp_vec(1'b1);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL single cyc%0d rdy/sv/so/fs/lb got=%b exp=%b", i, got, exp);
      end
      if (sv_m) begin s = {s[2:0], so_m}; nv++; end
      if (pend) begin
        pend = !(mq.size() <= 1);
        drive(1'b1, 4'b1011, 1'b0, '0);
      end else drive(1'b0, '0, 1'b0, '0);
    end
    n_cmp++;
    if (s !== 4'b1011 || nv != 4) begin
      n_bad++;
      $display("[TB] FAIL single_stream got=%b/%0d exp=1011/4", s, nv);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    logic [7:0] s = '0;
    int nv = 0;
    logic [W-1:0] pend[$] = '{4'b1100, 4'b0011};
    bit acc;
    for (int i = 0; i < 2 * W + 3; i++) begin
      @(negedge clk);
      got = {rdy_m, sv_m, so_m, fs_m, lb_m}; exp = exp_vec(1'b1);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL back_to_back cyc%0d rdy/sv/so/fs/lb got=%b exp=%b", i, got, exp);
      end
      if (sv_m) begin s = {s[6:0], so_m}; nv++; end
      if (pend.size() > 0) begin
        acc = (mq.size() <= 1);
        drive(1'b1, pend[0], 1'b0, '0);
        if (acc) void'(pend.pop_front());
      end else drive(1'b0, '0, 1'b0, '0);
    end
    n_cmp++;
    if (s !== 8'b11000011 || nv != 8) begin
      n_bad++;
      $display("[TB] FAIL back_to_back_stream got=%b/%0d exp=11000011/8", s, nv);
    end
  endtask

  task automatic test_busy_hold();
    logic [4:0] got, exp;
    logic [7:0] s = '0;
    int acc_cyc = -1;
    logic [W-1:0] pend[$] = '{4'b1001, 4'b0110};
    bit acc;
    for (int i = 0; i < 2 * W + 3; i++) begin
      @(negedge clk);
      got = {rdy_m, sv_m, so_m, fs_m, lb_m}; exp = exp_vec(1'b1);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL busy_hold cyc%0d rdy/sv/so/fs/lb got=%b exp=%b", i, got, exp);
      end
      if (sv_m) s = {s[6:0], so_m};
      if (pend.size() > 0) begin
        acc = rdy_m;
        drive(1'b1, pend[0], 1'b0, '0);
        if (acc) begin
          if (pend.size() == 1) acc_cyc = i;
          void'(pend.pop_front());
        end
      end else drive(1'b0, '0, 1'b0, '0);
    end
    n_cmp++;
    if (s !== 8'b10010110 || acc_cyc != 4) begin
      n_bad++;
      $display("[TB] FAIL busy_hold_stream got=%b/acc%0d exp=10010110/acc4", s, acc_cyc);
    end
  endtask

  task automatic test_lsb_first();
    logic [4:0] got, exp;
    logic [3:0] s = '0;
    bit pend = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      got = {rdy_l, sv_l, so_l, fs_l, lb_l}; exp = exp_vec(1'b0);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL lsb_first cyc%0d rdy/sv/so/fs/lb got=%b exp=%b", i, got, exp);
      end
      if (sv_l) s = {s[2:0], so_l};
      if (pend) begin
        pend = !(lq.size() <= 1);
        drive(1'b0, '0, 1'b1, 4'b1101);
      end else drive(1'b0, '0, 1'b0, '0);
    end
    n_cmp++;
    if (s !== 4'b1011) begin
      n_bad++;
      $display("[TB] FAIL lsb_stream got=%b exp=1011", s);
    end
  endtask

  task automatic test_reset_midword();
    logic [4:0] got, exp;
    logic [3:0] s = '0;
    bit pend = 1'b1;
    @(negedge clk);
    drive(1'b1, 4'b1111, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0);
    // Abort during bit 2, well away from the next rising edge.
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    got = {rdy_m, sv_m, so_m, fs_m, lb_m};
    n_cmp++;
    if (got !== 5'b10000) begin
      n_bad++;
      $display("[TB] FAIL abort_async rdy/sv/so/fs/lb got=%b exp=10000", got);
    end
    mq.delete(); lq.delete();
    lv_m = 1'b1; d_m = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {rdy_m, sv_m, so_m, fs_m, lb_m};
      n_cmp++;
      if (got !== 5'b10000) begin
        n_bad++;
        $display("[TB] FAIL abort_hold cyc%0d rdy/sv/so/fs/lb got=%b exp=10000", i, got);
      end
    end
    lv_m = 1'b0;
    clear = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      if (pend) begin
        pend = !(mq.size() <= 1);
        drive(1'b1, 4'b0101, 1'b0, '0);
      end else drive(1'b0, '0, 1'b0, '0);
      @(negedge clk);
      got = {rdy_m, sv_m, so_m, fs_m, lb_m}; exp = exp_vec(1'b1);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL after_abort cyc%0d rdy/sv/so/fs/lb got=%b exp=%b", i, got, exp);
      end
      if (sv_m) s = {s[2:0], so_m};
    end
    n_cmp++;
    if (s !== 4'b0101) begin
      n_bad++;
      $display("[TB] FAIL after_abort_stream got=%b exp=0101", s);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_random();
    logic [4:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      got = {rdy_m, sv_m, so_m, fs_m, lb_m}; exp = exp_vec(1'b1);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL random_msb cyc%0d rdy/sv/so/fs/lb got=%b exp=%b", i, got, exp);
      end
      got = {rdy_l, sv_l, so_l, fs_l, lb_l}; exp = exp_vec(1'b0);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL random_lsb cyc%0d rdy/sv/so/fs/lb got=%b exp=%b", i, got, exp);
      end
      drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0, W'($urandom));
    end
  endtask

  initial begin
    clear = 1'b0;
    lv_m = 1'b0; d_m = '0; lv_l = 1'b0; d_l = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_hold();
    test_lsb_first();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
